// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W     = 9;
  localparam int MEM_ARB_DATA_W     = 32;
  localparam int MEM_ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_RSP  = 2'b10
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed CPU priority with a starvation counter that forces a loader grant.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = MEM_ARB_STARVE_MAX,
  localparam int CW = $clog2(STARVE_MAX + 1)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  logic   grant_i,
  output owner_e owner_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sat;
  logic          both;

  always_comb begin
    sat  = (cnt_q == CW'(STARVE_MAX));
    both = cpu_req_i & ldr_req_i;
    if (ldr_req_i && (!cpu_req_i || sat))
      owner_o = OWN_LDR;
    else
      owner_o = OWN_CPU;
    cnt_d = cnt_q;
    if (grant_i) begin
      if (owner_o == OWN_LDR)
        cnt_d = '0;
      else if (both && !sat)
        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle reads.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ARB_ADDR_W,
  parameter int DATA_W     = MEM_ARB_DATA_W,
  parameter int STARVE_MAX = MEM_ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_e            state_q;
  owner_e            own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wren_q;
  logic              rden_q;
  logic              cpu_ack_q;
  logic              ldr_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;

  owner_e            win;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rd_rsp;

  assign grant = (state_q == S_IDLE) & (cpu_req | ldr_req);

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .cpu_req_i(cpu_req),
    .ldr_req_i(ldr_req),
    .grant_i  (grant),
    .owner_o  (win)
  );

  always_comb begin
    win_we    = cpu_we;
    win_addr  = cpu_addr;
    win_wdata = cpu_wdata;
    if (win == OWN_LDR) begin
      win_we    = ldr_we;
      win_addr  = ldr_addr;
      win_wdata = ldr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      own_q       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            state_q <= S_ACC;
            own_q   <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            wren_q  <= win_we;
            rden_q  <= !win_we;
          end
        end
        S_ACC: begin
          state_q   <= S_RSP;
          cpu_ack_q <= (own_q == OWN_CPU);
          ldr_ack_q <= (own_q == OWN_LDR);
        end
        S_RSP: begin
          state_q <= S_IDLE;
          if (!we_q && own_q == OWN_CPU)
            cpu_rdata_q <= ram_q;
          if (!we_q && own_q == OWN_LDR)
            ldr_rdata_q <= ram_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM q only arrives in RSP, so read data bypasses the hold register then
  assign rd_rsp = (state_q == S_RSP) & !we_q;

  assign cpu_rdata = (rd_rsp && own_q == OWN_CPU) ? ram_q : cpu_rdata_q;
  assign ldr_rdata = (rd_rsp && own_q == OWN_LDR) ? ram_q : ldr_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wren  = wren_q;
  assign ram_rden  = rden_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-low.
REQ-002 Parameter ADDR_W, default 9, word-address width of the shared RAM.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter STARVE_MAX, default 4, consecutive contended CPU grants before the loader is forced a grant.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-low reset.
REQ-007 cpu_req / cpu_we  in  1 / 1  CPU access request; write when cpu_we=1.
REQ-008 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-010 cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1.
REQ-011 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: same directions and widths as the CPU port, for the program loader / DMA port.
REQ-012 ram_addr / ram_wdata  out  ADDR_W / DATA_W  to the single-port RAM.
REQ-013 ram_wren / ram_rden  out  1 / 1  RAM write and read strobes.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ACC and RSP.
- IDLE -> ACC when any req=1.
- ACC -> RSP unconditionally.
- RSP -> IDLE unconditionally.
REQ-016 The owner SHALL be latched on the IDLE->ACC edge, together with the winner's we, addr and wdata.
REQ-017 All ram_* outputs SHALL be registered.
- In ACC: ram_addr = latched addr; ram_wren = latched we; ram_rden = !latched we.
- Outside ACC: ram_wren = 0 and ram_rden = 0.
REQ-018 The RAM read latency SHALL be 1 cycle. In RSP, the owner's ack = 1 and the owner's rdata = RAM q (reads only). For a write, rdata holds its previous value.
REQ-019 Latency from a req sampled in IDLE to ack SHALL be exactly 2 cycles; throughput is one access per 3 cycles.
REQ-020 Only the owner's ack SHALL pulse; both acks SHALL never be high in the same cycle.
REQ-021 A requester SHALL hold req, we, addr and wdata stable until its ack. A req still high in the cycle after ack is a new request.
REQ-022 Arbitration SHALL be fixed priority to the CPU, with a starvation guard:
- Contended grant to the CPU (both req=1): starve_cnt increments.
- Any grant to the loader: starve_cnt clears.
- Uncontended grant: starve_cnt is unchanged.
- When starve_cnt = STARVE_MAX and both req=1, the loader wins.
REQ-023 starve_cnt SHALL be ceil(log2(STARVE_MAX+1)) bits wide and saturate at STARVE_MAX.
REQ-024 A req that drops while the block is in ACC or RSP SHALL NOT abort the access; the access completes and ack still pulses.
REQ-025 A non-owner request that arrives during ACC or RSP SHALL wait, and is arbitrated in the next IDLE.

Reset
REQ-026 While reset=0 at a clock edge, the next state SHALL be IDLE, with:
- cpu_ack = ldr_ack = 0
- ram_wren = ram_rden = 0
- busy = 0
- starve_cnt = 0
- cpu_rdata = ldr_rdata = 0
- ram_addr = 0, ram_wdata = 0
REQ-027 A RAM write already strobed in ACC when reset is sampled low SHALL still complete, because the RAM itself is not reset. The pending ack SHALL be dropped.

Structure
REQ-028 The state encodings (IDLE=2'b00, ACC=2'b01, RSP=2'b10), the owner encoding (OWN_CPU=0, OWN_LDR=1) and the default parameters SHALL live in a shared mem_arb_pkg header.
REQ-029 The winner-select logic and starve_cnt SHALL be one sub-module, mem_arb_prio. The FSM and datapath registers SHALL stay in mem_arbiter.

Verification
REQ-030 Single CPU read: cpu_req=1, we=0, addr=9'h010, RAM[0x10]=32'hDEADBEEF -> ram_rden=1 in cycle 1; cpu_ack=1 with cpu_rdata=32'hDEADBEEF in cycle 2.
REQ-031 Loader write then CPU read: ldr writes 32'h12345678 to 9'h1FF (the top address); the CPU then reads 9'h1FF -> ldr_ack after 2 cycles; cpu_rdata=32'h12345678.
REQ-032 Simultaneous req, STARVE_MAX=4: both req held continuously -> grant order CPU, CPU, CPU, CPU, LDR, CPU...; starve_cnt returns to 0 after the LDR grant.
REQ-033 Back-to-back CPU: cpu_req held high for 3 accesses -> cpu_ack in cycles 2, 5, 8; busy drops only in cycles 3, 6, 9.
REQ-034 Reset mid-access: reset=0 sampled during ACC of a CPU write of 32'hA5A5A5A5 to 9'h020 -> next cycle IDLE with all outputs 0; no cpu_ack; RAM[0x20]=32'hA5A5A5A5.
REQ-035 Req drop: cpu_req deasserted during ACC -> the access still completes and cpu_ack=1 in RSP.
